// File: rtl/cla_adder_pipe.sv
// Pipelined two-level carry-lookahead adder/subtractor.
// Bit and group propagate/generate are registered first; group and bit carries resolve in the last stage.
module cla_adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             g_out,
  output logic             p_out
);

  localparam int NG  = WIDTH / 4;
  localparam int PGW = 2*WIDTH + 2*NG + 1;
  localparam int RW  = WIDTH + 4;

  logic [WIDTH-1:0] be, gb, pb;
  logic             c0;
  logic [NG-1:0]    gg, pg;
  logic [PGW-1:0]   pg_in, pg_last;

  assign be    = b ^ {WIDTH{sub}};
  assign c0    = sub ? ~cin : cin;
  assign gb    = a & be;
  assign pb    = a ^ be;
  assign pg_in = {gb, pb, gg, pg, c0};

  always_comb begin
    gg = '0;
    pg = '0;
    for (int j = 0; j < NG; j++) begin
      gg[j] = gb[4*j+3]
            | (pb[4*j+3] & gb[4*j+2])
            | (pb[4*j+3] & pb[4*j+2] & gb[4*j+1])
            | (pb[4*j+3] & pb[4*j+2] & pb[4*j+1] & gb[4*j]);
      pg[j] = &pb[4*j +: 4];
    end
  end

  // Second-level lookahead: every group carry is a flat sum of products.
  function automatic logic [RW-1:0] finish(input logic [PGW-1:0] x);
    logic [WIDTH-1:0] g, p;
    logic [NG-1:0]    gx, px;
    logic [NG:0]      cg;
    logic [WIDTH:0]   c;
    logic             cx, t, gw;
    g  = x[PGW-1 -: WIDTH];
    p  = x[PGW-1-WIDTH -: WIDTH];
    gx = x[2*NG -: NG];
    px = x[NG -: NG];
    cx = x[0];
    gw = 1'b0;
    c  = '0;
    for (int j = 0; j <= NG; j++) begin
      cg[j] = cx;
      for (int m = 0; m < j; m++) cg[j] = cg[j] & px[m];
      for (int k = 0; k < j; k++) begin
        t = gx[k];
        for (int m = k + 1; m < j; m++) t = t & px[m];
        cg[j] = cg[j] | t;
      end
    end
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i < 4; i++) begin
        c[4*j+i] = cg[j];
        for (int m = 0; m < i; m++) c[4*j+i] = c[4*j+i] & p[4*j+m];
        for (int k = 0; k < i; k++) begin
          t = g[4*j+k];
          for (int m = k + 1; m < i; m++) t = t & p[4*j+m];
          c[4*j+i] = c[4*j+i] | t;
        end
      end
    end
    c[WIDTH] = cg[NG];
    for (int k = 0; k < NG; k++) begin
      t = gx[k];
      for (int m = k + 1; m < NG; m++) t = t & px[m];
      gw = gw | t;
    end
    return {p ^ c[WIDTH-1:0], c[WIDTH], c[WIDTH] ^ c[WIDTH-1], gw, &px};
  endfunction

  logic [STAGES-1:0] v_q, v_d, rdy, vin, ld;
  logic [RW-1:0]     res_q, res_d;
  logic              acc;

  assign acc = in_valid & rdy[0];

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_hs
    // A stage can take data if it or any stage after it is empty.
    assign rdy[k] = out_ready | ~(&v_q[STAGES-1:k]);
    if (k == 0) begin : g_first
      assign vin[k] = acc;
    end else begin : g_next
      assign vin[k] = v_q[k-1];
    end
  end

  assign ld = rdy & vin;

  always_comb begin
    v_d = v_q;
    for (int s = 0; s < STAGES; s++)
      if (rdy[s]) v_d[s] = vin[s];
  end

  always_ff @(posedge clk) begin
    if (rst) v_q <= '0;
    else     v_q <= v_d;
  end

  if (STAGES == 1) begin : g_one
    assign pg_last = pg_in;
  end else begin : g_multi
    logic [PGW-1:0] pg_q [STAGES-1];
    always_ff @(posedge clk) begin
      if (ld[0]) pg_q[0] <= pg_in;
      for (int s = 1; s < STAGES - 1; s++)
        if (ld[s]) pg_q[s] <= pg_q[s-1];
    end
    assign pg_last = pg_q[STAGES-2];
  end

  assign res_d = finish(pg_last);

  always_ff @(posedge clk) begin
    if (rst)                  res_q <= '0;
    else if (ld[STAGES-1])    res_q <= res_d;
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[STAGES-1];
  assign {sum, cout, ovf, g_out, p_out} = res_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Scoreboard bench for cla_adder_pipe: random and directed operations
// against an arithmetic reference model, with backpressure and reset.
module tb_cla_adder_pipe;

  localparam int W = 16;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, sub, cin;
  logic         out_valid, out_ready, cout, ovf, g_out, p_out;
  logic [W-1:0] a, b, sum;

  cla_adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .g_out(g_out), .p_out(p_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout, ovf, g, p;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, last_stall = -1;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ia, ib,
                                 input logic s, c);
    exp_t e;
    logic [W-1:0] eb;
    logic         ec;
    logic [W:0]   full, raw;
    int           r;
    eb   = s ? ~ib : ib;
    ec   = s ? ~c : c;
    full = {1'b0, ia} + {1'b0, eb} + {{W{1'b0}}, ec};
    raw  = {1'b0, ia} + {1'b0, eb};
    r    = $signed(ia) + $signed(eb) + int'(ec);
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (r > 32767) || (r < -32768);
    e.g    = raw[W];
    e.p    = ((ia ^ eb) == {W{1'b1}});
    e.acc  = 0;
    return e;
  endfunction

  // Issue side of the scoreboard
  always @(negedge clk) begin
    if (!out_ready) last_stall = cyc;
    if (rst) sb.delete();
    else if (in_valid && in_ready) begin
      exp_t e;
      e = model(a, b, sub, cin);
      e.acc = cyc;
      sb.push_back(e);
    end
  end

  // Output monitor
  logic          was_rst = 1'b0, held_v = 1'b0;
  logic [W+3:0]  held;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      was_rst = 1'b1;
      held_v  = 1'b0;
    end else begin
      int inflight;
      if (was_rst) begin
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        chk("post_rst_sum", 64'(sum), 64'd0);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        was_rst = 1'b0;
      end
      if (held_v) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'({sum, cout, ovf, g_out, p_out}), 64'(held));
      end
      inflight = sb.size() - ((in_valid && in_ready) ? 1 : 0);
      chk("in_ready", 64'(in_ready), 64'(out_ready || (inflight < S)));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL stale_result: got sum %0h expected no output", sum);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sum", 64'(sum), 64'(e.sum));
          chk("cout", 64'(cout), 64'(e.cout));
          chk("ovf", 64'(ovf), 64'(e.ovf));
          chk("g_out", 64'(g_out), 64'(e.g));
          chk("p_out", 64'(p_out), 64'(e.p));
          if (e.acc > last_stall)
            chk("latency", 64'(cyc - e.acc), 64'(S));
        end
      end
      held_v = out_valid && !out_ready;
      held   = {sum, cout, ovf, g_out, p_out};
    end
  end

  task automatic op(input logic [W-1:0] ia, ib, input logic s, c);
    int n = 0;
    in_valid = 1'b1;
    a = ia; b = ib; sub = s; cin = c;
    do begin
      @(negedge clk); #2;
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 100 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  logic rnd_on = 1'b0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_on) out_ready = ($urandom_range(0, 9) < 7);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    op(16'h0005, 16'h0007, 1'b1, 1'b0);
    op(16'hAAAA, 16'h5555, 1'b0, 1'b1);
    op(16'h0000, 16'h0000, 1'b1, 1'b1);
    op(16'h8000, 16'h0001, 1'b1, 1'b0);
    op(16'h0000, 16'hFFFF, 1'b1, 1'b0);
    drain();

    out_ready = 1'b0;
    fork
      begin
        op(16'h1234, 16'h1111, 1'b0, 1'b0);
        op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        op(16'h4000, 16'h4000, 1'b0, 1'b0);
        op(16'h0001, 16'h0002, 1'b1, 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    rnd_on = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    rnd_on = 1'b0;
    drain();

    out_ready = 1'b0;
    op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    op(16'h9999, 16'h6666, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    op(16'h0003, 16'h0004, 1'b0, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
